// File: rtl/mult_wb_queue.sv
// mult_wb_queue: in-order result queue behind the non-stalling mul/div unit.
// Every result is absorbed into a small circular buffer and drained onto a
// valid/ready writeback port. Issue is throttled against queued plus
// in-flight operations so a result can never land on a full queue.
module mult_wb_queue #(
  parameter int DEPTH         = 4,
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int MAX_INFLIGHT  = 4,
  // Overflow is a hard error in normal use; a bench that provokes it on
  // purpose can switch the overflow assertion off.
  parameter bit CHK_OVF       = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       issue_fire_i,
  output logic                       issue_ready_o,
  input  logic                       res_valid_i,
  input  logic [XLEN-1:0]            res_i,
  input  logic [TRANS_ID_BITS-1:0]   res_trans_id_i,
  output logic                       wb_valid_o,
  output logic [XLEN-1:0]            wb_result_o,
  output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
  input  logic                       wb_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IF_W  = $clog2(MAX_INFLIGHT+1);

  logic [XLEN-1:0]          res_q [DEPTH];
  logic [TRANS_ID_BITS-1:0] id_q  [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [IF_W-1:0]  inflight;
  logic             ovf;

  logic full, pop, push_req, push, ovf_evt, inc, dec;

  // Handshake decode; flush masks both incoming results and issues.
  always_comb begin
    full     = (count == CNT_W'(DEPTH));
    pop      = (count != '0) && wb_ready_i;
    push_req = res_valid_i && !flush_i;
    // A pop in the same edge frees the slot, so a full queue still accepts.
    push     = push_req && (!full || pop);
    ovf_evt  = push_req && full && !pop;
    inc      = issue_fire_i && !flush_i;
    dec      = push_req;
  end

  // Entry storage; no reset needed since validity is tracked by count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      res_q[wr_ptr] <= res_i;
      id_q[wr_ptr]  <= res_trans_id_i;
    end
  end

  // Pointers, occupancy, in-flight tracking and sticky overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      ovf      <= 1'b0;
    end else begin
      if (ovf_evt) ovf <= 1'b1;
      if (flush_i) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        inflight <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: ;
        endcase
        if (inc && !dec && inflight != IF_W'(MAX_INFLIGHT))
          inflight <= inflight + IF_W'(1);
        else if (dec && !inc && inflight != '0)
          inflight <= inflight - IF_W'(1);
      end
    end
  end

  // Outputs come straight from registered state, no bypass from the inputs.
  always_comb begin
    wb_valid_o    = (count != '0);
    wb_result_o   = res_q[rd_ptr];
    wb_trans_id_o = id_q[rd_ptr];
    count_o       = count;
    overflow_o    = ovf;
    issue_ready_o = ((int'(count) + int'(inflight)) < DEPTH) &&
                    (int'(inflight) < MAX_INFLIGHT);
  end

  // Protocol checks: dropped results and issuing past the throttle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (CHK_OVF)
        assert (!ovf_evt) else $error("mult_wb_queue: result dropped, queue full");
      assert (!(issue_fire_i && !issue_ready_o))
        else $error("mult_wb_queue: issue while issue_ready_o low");
    end
  end

endmodule

// File: doc/mult_wb_queue.md
Name: mult_wb_queue

Overview:
- Result queue directly downstream of the multiply/divide functional unit. The multiplier cannot stall, so this block absorbs every result and trans_id.
- Results drain in order onto a shared writeback port that uses a valid/ready handshake.
- It tracks multiply operations in flight and throttles issue, so a result never arrives while the queue is full.

Parameters:
DEPTH  4  queue entries (power of two, >=2)
XLEN  64  result width
TRANS_ID_BITS  3  transaction ID width
MAX_INFLIGHT  4  maximum issued-but-unreturned operations tracked (counter width = $clog2(MAX_INFLIGHT+1))

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-high reset
flush_i  in  1  squash queue and in-flight tracking
issue_fire_i  in  1  one operation accepted by the functional unit this cycle
issue_ready_o  out  1  issue may send another operation
res_valid_i  in  1  functional unit result valid (no backpressure)
res_i  in  XLEN  result data
res_trans_id_i  in  TRANS_ID_BITS  result transaction ID
wb_valid_o  out  1  head entry valid
wb_result_o  out  XLEN  head result
wb_trans_id_o  out  TRANS_ID_BITS  head transaction ID
wb_ready_i  in  1  writeback accepts head
count_o  out  $clog2(DEPTH+1)  current occupancy
overflow_o  out  1  sticky error flag

Behaviour:
- Reset (async, rst_i=1), applies immediately and also mid-operation:
  - Read pointer, write pointer, count and in-flight counter go to 0.
  - overflow_o=0, wb_valid_o=0, count_o=0, issue_ready_o=1.
  - wb_result_o and wb_trans_id_o are don't-care while wb_valid_o=0.
- Storage:
  - Circular buffer of DEPTH {result, trans_id} entries with wrapping pointers.
  - Order is strictly FIFO.
- Push: res_valid_i=1 writes {res_i, res_trans_id_i} at the write pointer on the edge.
  - The entry appears on wb_* the next cycle, so minimum latency is 1 cycle; there is no combinational bypass.
- Pop: when wb_valid_o && wb_ready_i, the head is consumed on the edge.
  - wb_* outputs depend only on registered state.
  - wb_valid_o = (count != 0).
- Simultaneous push and pop: count unchanged and both pointers advance.
  - Allowed when full, since the pop frees the slot in the same edge.
- Overflow: a push when count==DEPTH with no pop in the same cycle sets overflow_o, sticky until reset.
  - The pushed data is dropped and the queue contents are unchanged.
  - Simulation assertion fires.
- In-flight counter:
  - Increments on issue_fire_i and decrements on res_valid_i.
  - When both occur in one cycle it is unchanged.
  - Saturates at 0 and at MAX_INFLIGHT.
- issue_ready_o = (count + inflight) < DEPTH && inflight < MAX_INFLIGHT, computed from registered state only.
  - issue_fire_i while issue_ready_o=0 is an upstream protocol error (assertion).
- Flush (flush_i=1), effective on the edge:
  - Count, both pointers and the in-flight counter go to 0.
  - res_valid_i and issue_fire_i in the same cycle are ignored.
  - wb_valid_o=0 the following cycle.
  - overflow_o is not cleared.
  - A pop handshake in the flush cycle is still considered completed.
- Empty: a pop request has no effect. wb_ready_i may be high at any time.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full versus empty is resolved by count.

Test Plan:
- Single result: issue_fire_i @t0; res_valid_i, res=0x1234, id=2 @t2 -> wb_valid_o=1 with 0x1234 / id 2 @t3; wb_ready_i=1 @t3 -> count_o=0 and wb_valid_o=0 @t4.
- Backpressure throttle: wb_ready_i=0, issue 4 ops with results 1..4 -> issue_ready_o falls after the 4th issue; count_o=4; drain gives 1,2,3,4 in order; issue_ready_o returns to 1 after the first pop.
- Full with simultaneous push and pop: count=4, res_valid_i=1 (0xAA) and wb_ready_i=1 in the same cycle -> count stays 4, overflow_o=0, 0xAA emerges 4th.
- Forced overflow: count=4, wb_ready_i=0, res_valid_i=1 -> overflow_o=1 and stays high; contents unchanged.
- Flush: 3 entries queued, 2 in flight, flush_i=1 together with res_valid_i=1 -> next cycle count_o=0, wb_valid_o=0, issue_ready_o=1, no entry appears.
- Async reset mid-drain: assert rst_i between edges with 2 entries queued -> wb_valid_o=0 and count_o=0 immediately, without waiting for a clock edge; normal operation resumes after release.
- Wrap: push and pop 10 results continuously with wb_ready_i=1 -> all 10 appear in order, each 1 cycle after push; count never exceeds 1.
